load_store_unit: RTL and testbench

Initiator side of the data-memory protocol. Sits between the execute stage and the byte-wide data RAM port. Accepts one load or store request per transaction and serialises it into little-endian byte beats (1, 2 or 4). For loads, reassembles the returned bytes and sign- or zero-extends them into a 32-bit response for writeback.

---
 rtl/load_store_unit_pkg.sv | 35 +++
 rtl/load_store_unit_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared instruction-class and funct3 codes for the data-memory initiator,
// plus request decode helpers used by the load/store sequencer.
package load_store_unit_pkg;

    localparam logic [4:0] LTYPE = 5'b00000;
    localparam logic [4:0] STYPE = 5'b01000;

    localparam logic [2:0] LB3  = 3'd0;
    localparam logic [2:0] LH3  = 3'd1;
    localparam logic [2:0] LW3  = 3'd2;
    localparam logic [2:0] LBU3 = 3'd4;
    localparam logic [2:0] LHU3 = 3'd5;
    localparam logic [2:0] SB3  = 3'd0;
    localparam logic [2:0] SH3  = 3'd1;
    localparam logic [2:0] SW3  = 3'd2;

    function automatic logic req_legal(input logic [4:0] itype, input logic [2:0] funct3);
        if (itype == LTYPE)
            return funct3 inside {LB3, LH3, LW3, LBU3, LHU3};
        else if (itype == STYPE)
            return funct3 inside {SB3, SH3, SW3};
        else
            return 1'b0;
    endfunction

    // Index of the final byte beat: 0, 1 or 3 for byte, half and word.
    function automatic logic [1:0] last_beat(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of an assembled little-endian load word; purely
// combinational so any load path (byte-serial or wide) can share it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        rdata_o = word_i;
        case (funct3_i)
            LB3:     rdata_o = {{24{word_i[7]}}, word_i[7:0]};
            LH3:     rdata_o = {{16{word_i[15]}}, word_i[15:0]};
            LBU3:    rdata_o = {24'h0, word_i[7:0]};
            LHU3:    rdata_o = {16'h0, word_i[15:0]};
            default: rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits a request into 1/2/4 little-endian
// byte beats on the data RAM port and rebuilds/extends load results.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; strobes low
// ST_STORE | one write beat per cycle, byte beat_q at addr_q+beat_q
// ST_LOAD  | one read beat per cycle; captures the previous beat's byte
// ST_DRAIN | no strobe; captures the last returned byte, extends result
// ST_RESP  | one-cycle completion pulse (err_q set for illegal requests)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [4:0]        itype_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_DRAIN,
        ST_RESP
    } lsu_state_e;

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        last_q, last_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        cap_idx;
    logic [31:0]       asm_word;
    logic [31:0]       ext_word;

    load_extend u_load_extend (
        .word_i   (asm_word),
        .funct3_i (f3_q),
        .rdata_o  (ext_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        beat_d      = beat_q;
        last_d      = last_q;
        f3_d        = f3_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Read data lags its strobe by a cycle, so LOAD fills the byte of the
        // previous beat while DRAIN (beat_q held at last) fills the final one.
        cap_idx = (state_q == ST_LOAD) ? beat_q - 2'd1 : beat_q;
        asm_word = data_q;
        asm_word[8*cap_idx +: 8] = mem_rdata_i;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d = addr_i;
                    data_d = wdata_i;
                    beat_d = '0;
                    last_d = last_beat(funct3_i);
                    f3_d   = funct3_i;
                    err_d  = 1'b0;
                    if (!req_legal(itype_i, funct3_i)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (itype_i == LTYPE) begin
                        data_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_STORE;
                    end
                end
            end
            ST_STORE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q + ADDR_W'(beat_q);
                mem_wdata_o = data_q[8*beat_q +: 8];
                if (beat_q == last_q) state_d = ST_RESP;
                else                  beat_d  = beat_q + 2'd1;
            end
            ST_LOAD: begin
                mem_re_o   = 1'b1;
                mem_addr_o = addr_q + ADDR_W'(beat_q);
                if (beat_q != 2'd0) data_d = asm_word;
                if (beat_q == last_q) state_d = ST_DRAIN;
                else                  beat_d  = beat_q + 2'd1;
            end
            ST_DRAIN: begin
                data_d  = asm_word;
                rdata_d = ext_word;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized transactions
// against a byte-memory reference model, and a mid-store reset sequence.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  itype_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .itype_i     (itype_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_re_o    (mem_re_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Byte RAM: writes land on the strobe edge, read data appears next cycle
    // (garbage otherwise so a mistimed capture is visible).
    logic [7:0] mem [bit [31:0]];

    function automatic logic [7:0] mrd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        mem_rdata_i <= mem_re_o ? mrd(mem_addr_o) : 8'($urandom);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          got_cyc;
    logic        got_err;
    logic [31:0] got_rdata;
    bit [31:0]   wa[$];
    logic [7:0]  wd[$];
    bit [31:0]   ra[$];
    int          viol;
    logic [31:0] model_rdata = 32'h0;

    // Entered and left on a negedge; cycle k is sampled k negedges after acceptance.
    task automatic run_txn(input logic [4:0] it, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wdat);
        wa.delete(); wd.delete(); ra.delete();
        got_cyc = -1; got_err = 1'bx; got_rdata = 'x; viol = 0;
        chk("ready_before_req", req_ready_o, 1);
        req_valid_i = 1'b1; itype_i = it; funct3_i = f3; addr_i = a; wdata_i = wdat;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid_i = 1'b0;
                itype_i = 5'($urandom); funct3_i = 3'($urandom);
                addr_i = $urandom; wdata_i = $urandom;
            end
            if (mem_we_o && mem_re_o) viol++;
            if (!mem_we_o && !mem_re_o && mem_addr_o != 0) viol++;
            if (!mem_we_o && mem_wdata_o != 0) viol++;
            if (req_ready_o) viol++;
            if (mem_we_o) begin wa.push_back(mem_addr_o); wd.push_back(mem_wdata_o); end
            if (mem_re_o) ra.push_back(mem_addr_o);
            if (rsp_valid_o) begin
                got_cyc = k; got_err = err_o; got_rdata = rdata_o;
                break;
            end
        end
        @(negedge clk);
        chk("rsp_single_pulse", rsp_valid_o, 0);
        chk("ready_after_resp", req_ready_o, 1);
        chk("bus_rules", viol, 0);
    endtask

    task automatic do_txn(input string tag, input logic [4:0] it, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wdat,
                          input bit use_tbl, input logic [31:0] t_rdata,
                          input logic t_err, input int t_cyc);
        bit          is_ld = (it == LTYPE);
        bit          is_st = (it == STYPE);
        bit          legal = (is_ld && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                             (is_st && f3 <= 3'd2);
        int          n = 1 << f3[1:0];
        longint      v = 0;
        logic [31:0] e_rdata;
        int          e_cyc;
        int          e_wr, e_rd;
        for (int i = 0; i < n; i++) v += longint'(mrd(a + 32'(i))) << (8 * i);
        if (is_ld && !f3[2] && n < 4 && v >= (64'sd1 << (8 * n - 1)))
            v -= (64'sd1 << (8 * n));
        if (!legal)     e_rdata = 32'h0;
        else if (is_ld) e_rdata = 32'(v);
        else            e_rdata = model_rdata;
        e_cyc = !legal ? 1 : (is_st ? n + 1 : n + 2);
        e_wr  = (legal && is_st) ? n : 0;
        e_rd  = (legal && is_ld) ? n : 0;

        run_txn(it, f3, a, wdat);

        chk({tag, " rsp_cycle"}, got_cyc, e_cyc);
        chk({tag, " err"}, got_err, !legal);
        chk({tag, " rdata"}, got_rdata, e_rdata);
        chk({tag, " n_writes"}, wa.size(), e_wr);
        chk({tag, " n_reads"}, ra.size(), e_rd);
        for (int i = 0; i < wa.size() && i < e_wr; i++) begin
            chk($sformatf("%s wr_addr%0d", tag, i), wa[i], a + 32'(i));
            chk($sformatf("%s wr_byte%0d", tag, i), wd[i], 8'(wdat >> (8 * i)));
        end
        for (int i = 0; i < ra.size() && i < e_rd; i++)
            chk($sformatf("%s rd_addr%0d", tag, i), ra[i], a + 32'(i));
        if (use_tbl) begin
            chk({tag, " tbl_rdata"}, got_rdata, t_rdata);
            chk({tag, " tbl_err"}, got_err, t_err);
            chk({tag, " tbl_cycle"}, got_cyc, t_cyc);
        end
        model_rdata = e_rdata;
    endtask

    typedef struct {
        logic [4:0]  it;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        bit          pre;
        logic [31:0] pre_bytes;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } vec_t;

    vec_t tbl[11];

    task automatic reset_check(input string tag);
        chk({tag, " ready"}, req_ready_o, 1);
        chk({tag, " rsp_valid"}, rsp_valid_o, 0);
        chk({tag, " rdata"}, rdata_o, 0);
        chk({tag, " err"}, err_o, 0);
        chk({tag, " mem_addr"}, mem_addr_o, 0);
        chk({tag, " mem_re"}, mem_re_o, 0);
        chk({tag, " mem_we"}, mem_we_o, 0);
        chk({tag, " mem_wdata"}, mem_wdata_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0]   ra_base;
        int          rsp_cnt;
        logic [4:0]  it;
        logic [2:0]  f3;
        logic [31:0] a;

        reset = 1'b0; req_valid_i = 1'b0; itype_i = '0; funct3_i = '0;
        addr_i = '0; wdata_i = '0;
        #1;
        reset_check("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        tbl[0]  = '{STYPE, 3'd2, 32'h0100_0000, 32'hDEAD_BEEF, 0, 32'h0,         32'h0000_0000, 0, 5};
        tbl[1]  = '{LTYPE, 3'd2, 32'h0100_0000, 32'h0,         0, 32'h0,         32'hDEAD_BEEF, 0, 6};
        tbl[2]  = '{LTYPE, 3'd0, 32'h0000_0200, 32'h0,         1, 32'h0000_0080, 32'hFFFF_FF80, 0, 3};
        tbl[3]  = '{LTYPE, 3'd4, 32'h0000_0200, 32'h0,         0, 32'h0,         32'h0000_0080, 0, 3};
        tbl[4]  = '{LTYPE, 3'd1, 32'h0000_0300, 32'h0,         1, 32'h0000_8534, 32'hFFFF_8534, 0, 4};
        tbl[5]  = '{LTYPE, 3'd5, 32'h0000_0300, 32'h0,         0, 32'h0,         32'h0000_8534, 0, 4};
        tbl[6]  = '{STYPE, 3'd1, 32'hFFFF_FFFF, 32'h0000_1234, 0, 32'h0,         32'h0000_8534, 0, 3};
        tbl[7]  = '{LTYPE, 3'd3, 32'h0000_0400, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 1};
        tbl[8]  = '{STYPE, 3'd3, 32'h0000_0400, 32'h5555_5555, 0, 32'h0,         32'h0000_0000, 1, 1};
        tbl[9]  = '{5'b11111, 3'd2, 32'h0000_0400, 32'h0,      0, 32'h0,         32'h0000_0000, 1, 1};
        tbl[10] = '{LTYPE, 3'd2, 32'hFFFF_FFFE, 32'h0,         1, 32'h4433_2211, 32'h4433_2211, 0, 6};

        for (int t = 0; t < 11; t++) begin
            if (tbl[t].pre)
                for (int i = 0; i < 4; i++)
                    mem[tbl[t].a + 32'(i)] = 8'(tbl[t].pre_bytes >> (8 * i));
            do_txn($sformatf("vec%0d", t), tbl[t].it, tbl[t].f3, tbl[t].a, tbl[t].wd,
                   1, tbl[t].rdata, tbl[t].err, tbl[t].cyc);
        end

        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: it = LTYPE;
                4, 5, 6, 7: it = STYPE;
                default:    it = 5'($urandom);
            endcase
            f3 = 3'($urandom);
            case ($urandom_range(0, 2))
                0:       a = 32'h0000_1000 + 32'($urandom_range(0, 7));
                1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            do_txn($sformatf("rnd%0d", r), it, f3, a, $urandom, 0, 32'h0, 1'b0, 0);
        end

        // Reset during beat 2 of a word store.
        ra_base = 32'h0000_2000;
        for (int i = 0; i < 4; i++) mem.delete(ra_base + 32'(i));
        req_valid_i = 1'b1; itype_i = STYPE; funct3_i = 3'd2;
        addr_i = ra_base; wdata_i = 32'hA1B2_C3D4;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid beat2_active", mem_we_o, 1);
        chk("rst_mid beat2_addr", mem_addr_o, ra_base + 32'd2);
        reset = 1'b0;
        #1;
        reset_check("rst_mid");
        rsp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid_o) rsp_cnt++;
            if (k == 2) reset = 1'b1;
        end
        chk("rst_mid no_rsp", rsp_cnt, 0);
        chk("rst_mid ready", req_ready_o, 1);
        chk("rst_mid byte0", mrd(ra_base), 8'hD4);
        chk("rst_mid byte1", mrd(ra_base + 32'd1), 8'hC3);
        chk("rst_mid byte2_absent", mem.exists(ra_base + 32'd2), 0);
        chk("rst_mid byte3_absent", mem.exists(ra_base + 32'd3), 0);
        model_rdata = 32'h0;
        do_txn("post_rst_lw", LTYPE, 3'd2, ra_base, 32'h0, 1, 32'h0000_C3D4, 1'b0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
